alarm_denetim: RTL
==================

# alarm_denetim

Downstream stage of the temperature/threshold comparator. Consumes its combinational `alarm` level and turns it into a debounced, latched, operator-acknowledged alarm. Drives a blinking buzzer and a saturating alarm-event counter for the lab board's LEDs and seven-segment display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles `alarm_in` must hold a level before a state change. Legal range 1..255.
- `BLINK_HALF`, default 8: buzzer half-period in clock cycles. Legal range 1..65535.
- `CNT_W`, default 8: width of `event_count`.

Ports:
- `clk` input, 1 bit: single system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `alarm_in` input, 1 bit: comparator alarm level, synchronous to `clk`.
- `ack` input, 1 bit: operator acknowledge, level, already synchronised to `clk`.
- `alarm_active` output, 1 bit: latched alarm, registered.
- `buzzer` output, 1 bit: blinking drive, registered.
- `state_o` output, 2 bits: current FSM state, for debug LEDs.
- `event_count` output, `CNT_W` bits: number of alarm entries, saturating.

## Operation
- Moore FSM with states IDLE=0, PENDING=1, ALARM=2, ACKED=3.
- A run counter `run` counts consecutive cycles in which `alarm_in` matches the level the current state is waiting for.
- IDLE:
  - `alarm_in`=1 → PENDING, `run`=1.
  - If `DEBOUNCE_CYCLES`=1, go directly to ALARM instead.
- PENDING:
  - `alarm_in`=0 → IDLE, `run`=0.
  - `alarm_in`=1 and `run`=`DEBOUNCE_CYCLES`-1 → ALARM.
  - Otherwise `run`+1.
- ALARM:
  - Latched. `alarm_in` is ignored.
  - `ack`=1 → ACKED, `run`=0.
- ACKED:
  - `alarm_in`=1 resets `run` to 0.
  - `alarm_in`=0 increments `run`.
  - When `run` reaches `DEBOUNCE_CYCLES`, go to IDLE.
  - `ack` is ignored.
- `ack` is honoured only in ALARM. `ack` held high across re-entry into ALARM acknowledges again one cycle later.
- Outputs per state:
  - `alarm_active` = 1 in ALARM and ACKED, 0 otherwise.
  - `buzzer` = 0 outside ALARM.
- Buzzer in ALARM:
  - `buzzer` goes to 1 on the entry edge.
  - It toggles every `BLINK_HALF` cycles.
  - The blink counter is cleared on every ALARM entry.
- `event_count` increments by 1 on every transition into ALARM and saturates at 2^`CNT_W`-1. It has no wrap-around.
- Reset, including mid-operation: state IDLE, `run`=0, blink counter 0, `alarm_active`=0, `buzzer`=0, `event_count`=0, `state_o`=0.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Entry latency:
  - `alarm_in` high at `DEBOUNCE_CYCLES` consecutive rising edges.
  - `alarm_active`, `buzzer` and `event_count` update immediately after the last of those edges.
  - With D=4: high at edges 1..4 → outputs change after edge 4.
- A single-cycle low in PENDING restarts debouncing from zero.
- Ack latency: `ack` sampled high at edge n in ALARM → `buzzer`=0 after edge n. `alarm_active` stays 1.
- Clear latency: in ACKED, `alarm_in` low at `DEBOUNCE_CYCLES` consecutive edges → `alarm_active`=0 after the last of them.
- Buzzer period is 2×`BLINK_HALF` cycles, 50% duty, first half high.
- `run` width is clog2(`DEBOUNCE_CYCLES`+1).
- Blink counter width is clog2(`BLINK_HALF`).

## Structure
- Shared package `alarm_pkg` holds:
  - the state typedef (2-bit enum IDLE/PENDING/ALARM/ACKED);
  - the default `DEBOUNCE_CYCLES` and `BLINK_HALF` constants.
- Sub-module `buzzer_flasor`:
  - inputs `clk`, `rst`, `en`, `restart`; output `out`;
  - parameter `BLINK_HALF`;
  - generates the toggle.
- The FSM, run counter and event counter stay in `alarm_denetim`.

## Test plan
- **Reset values:** assert `rst` mid-ALARM with `buzzer`=1 → all outputs 0 asynchronously; FSM in IDLE after release.
- **Debounce glitch:** D=4, `alarm_in` high 3 cycles, low 1, high 4 → `alarm_active` rises only after the 7th high edge; `event_count`=1.
- **Blink and ack:** BLINK_HALF=8, in ALARM → `buzzer` 1 for 8 cycles, 0 for 8, repeating. `ack` pulse at cycle 20 → `buzzer`=0 next cycle, `alarm_active`=1, `state_o`=3.
- **Latch:** in ALARM drop `alarm_in` for 50 cycles without `ack` → state stays ALARM, `alarm_active`=1.
- **Clear with re-rise:** in ACKED, `alarm_in` low 3 cycles, high 1, low 4 → IDLE after the final 4th low edge.
- **Saturation:** CNT_W=2, drive 5 alarm/ack/clear cycles → `event_count` 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default parameters for the alarm supervision block.
package alarm_pkg;

  // FSM encoding is visible on the debug LEDs, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    ACKED   = 2'd3
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_BLINK_HALF      = 8;

endpackage

// File: rtl/buzzer_flasor.sv
// Buzzer blink generator: square wave, first half high, half-period BLINK_HALF.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   en      - blink enabled this cycle; low forces out=0 and clears the counter
//   restart - start a fresh period (out=1, counter cleared) on this edge
//   out     - registered buzzer drive
module buzzer_flasor
  import alarm_pkg::*;
#(
  parameter int unsigned BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic out
);

  localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;

  // Half-period counter and output toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      out <= 1'b1;
    end else if (cnt == LAST) begin
      cnt <= '0;
      out <= ~out;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alarm_denetim.sv
// Debounced, latched, operator-acknowledged alarm with blinking buzzer and
// saturating alarm-entry counter.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   alarm_in     - comparator alarm level
//   ack          - operator acknowledge level (honoured only in ALARM)
//   alarm_active - registered, high in ALARM and ACKED
//   buzzer       - registered blink drive, active only in ALARM
//   state_o      - current FSM state for debug LEDs
//   event_count  - saturating count of ALARM entries
module alarm_denetim
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alarm_in,
  input  logic             ack,
  output logic             alarm_active,
  output logic             buzzer,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned RUN_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic             enter_c;
  logic             in_alarm_c;

  // Next-state and run-counter logic
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    unique case (state)
      IDLE: begin
        run_nxt = '0;
        if (alarm_in) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = ALARM;
          end else begin
            state_nxt = PENDING;
            run_nxt   = RUN_W'(1);
          end
        end
      end
      PENDING: begin
        if (!alarm_in) begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end else if (run == RUN_LAST) begin
          state_nxt = ALARM;
          run_nxt   = '0;
        end else begin
          run_nxt = run + RUN_W'(1);
        end
      end
      ALARM: begin
        run_nxt = '0;
        if (ack) begin
          state_nxt = ACKED;
        end
      end
      ACKED: begin
        // Clears only after DEBOUNCE_CYCLES uninterrupted low samples.
        if (alarm_in) begin
          run_nxt = '0;
        end else if (run == RUN_LAST) begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end else begin
          run_nxt = run + RUN_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        run_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they change on the entry edge.
  assign in_alarm_c = (state_nxt == ALARM);
  assign enter_c    = in_alarm_c && (state != ALARM);

  // State, run counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      run          <= '0;
      alarm_active <= 1'b0;
      event_count  <= '0;
    end else begin
      state        <= state_nxt;
      run          <= run_nxt;
      alarm_active <= (state_nxt == ALARM) || (state_nxt == ACKED);
      if (enter_c && (event_count != CNT_MAX)) begin
        event_count <= event_count + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

  buzzer_flasor #(
    .BLINK_HALF(BLINK_HALF)
  ) u_buzzer (
    .clk    (clk),
    .rst    (rst),
    .en     (in_alarm_c),
    .restart(enter_c),
    .out    (buzzer)
  );

endmodule
